// File: rtl/mc_controller.sv
// Main control FSM for the multicycle RV32I core: sequences Fetch/Decode/Execute/
// Memory/Writeback, drives datapath enables and selects, counts retired instructions.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC into IR, PC <= PC + 4
// DECODE   | read register file, precompute OldPC + imm (branch target)
// MEMADR   | compute rs1 + imm for load/store
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 data to memory at ALUOut
// EXECR    | R-type ALU operation rs1 op rs2
// EXECI    | I-type ALU operation rs1 op imm
// JAL      | PC <= target, compute OldPC + 4 as link value
// BEQ      | compare rs1 - rs2, take branch on Zero
// ALUWB    | write ALUOut to rd
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             RegWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_JAL,
        S_BEQ,
        S_ALUWB
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;

    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic [1:0] w_alu_op;
    logic       w_retire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        w_alu_op    = 2'b00;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_JAL:            w_next = S_JAL;
                    OP_BRANCH:         w_next = S_BEQ;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b00;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b00;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
                w_next   = S_FETCH;
            end
            S_ALUWB: begin
                ResultSrc   = 2'b00;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    // Subtract only for R-type with funct7[5]; addi ignores instr[30].
    always_comb begin
        ALUControl = 3'b000;
        case (w_alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                      (r_state == S_ALUWB) || (r_state == S_BEQ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Enables are gated by rst so nothing writes while reset is held.
    assign PCWrite       = rst & (w_pc_update | (w_branch & Zero));
    assign IRWrite       = rst & w_ir_write;
    assign MemWrite      = rst & w_mem_write;
    assign RegWrite      = rst & w_reg_write;
    assign illegal       = rst & w_illegal;
    assign instr_retired = r_retired;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes the expected output vector
// for every cycle, a negedge monitor pops and compares.
module tb_mc_controller;

    localparam int CNT_W = 32;
    localparam int VW    = 17 + CNT_W;

    logic             clk;
    logic             rst;
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             Zero;
    logic             PCWrite;
    logic             AdrSrc;
    logic             MemWrite;
    logic             IRWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ImmSrc;
    logic [2:0]       ALUControl;
    logic             RegWrite;
    logic             illegal;
    logic [CNT_W-1:0] instr_retired;

    mc_controller #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .Zero         (Zero),
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ImmSrc       (ImmSrc),
        .ALUControl   (ALUControl),
        .RegWrite     (RegWrite),
        .illegal      (illegal),
        .instr_retired(instr_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [VW-1:0]    q_exp[$];
    string            q_name[$];
    int               total = 0;
    int               bad   = 0;
    logic [CNT_W-1:0] ret_exp = '0;
    string            tname = "reset";

    logic [VW-1:0] m_exp;
    logic [VW-1:0] m_act;
    string         m_name;

    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            m_exp  = q_exp.pop_front();
            m_name = q_name.pop_front();
            m_act  = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                      ImmSrc, ALUControl, RegWrite, illegal, instr_retired};
            total++;
            if (m_act !== m_exp) begin
                bad++;
                $display("FAIL %s check#%0d actual=%h required=%h", m_name, total, m_act, m_exp);
            end
        end
    end

    // Field order: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl RegWrite illegal
    task automatic push_exp(input logic pcw, input logic adr, input logic mw, input logic irw,
                            input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                            input logic [1:0] imm, input logic [2:0] alu, input logic rw,
                            input logic ill);
        q_exp.push_back({pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill, ret_exp});
        q_name.push_back(tname);
    endtask

    task automatic chk(input logic pcw, input logic adr, input logic mw, input logic irw,
                       input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] imm, input logic [2:0] alu, input logic rw,
                       input logic ill);
        push_exp(pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [1:0] imm);
        chk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
    endtask

    task automatic decode(input logic [1:0] imm);
        chk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0);
    endtask

    task automatic in_reset(input logic [1:0] imm);
        chk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
    endtask

    task automatic run_r(input string nm, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        tname = nm; op = 7'b0110011; funct3 = f3; funct7b5 = f7; Zero = 0;
        fetch(2'b00);
        decode(2'b00);
        chk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0, 0);
        chk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
        ret_exp++;
    endtask

    task automatic run_i(input string nm, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        tname = nm; op = 7'b0010011; funct3 = f3; funct7b5 = f7; Zero = 0;
        fetch(2'b00);
        decode(2'b00);
        chk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0, 0);
        chk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
        ret_exp++;
    endtask

    task automatic run_beq(input string nm, input logic z);
        tname = nm; op = 7'b1100011; funct3 = 3'b000; funct7b5 = 0; Zero = z;
        fetch(2'b10);
        decode(2'b10);
        chk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 0);
        ret_exp++;
    endtask

    initial begin
        rst = 0; op = 7'b0000000; funct3 = 3'b000; funct7b5 = 0; Zero = 0;
        @(posedge clk);
        #1;
        repeat (3) in_reset(2'b00);
        rst = 1;

        tname = "lw"; op = 7'b0000011; funct3 = 3'b010;
        fetch(2'b00);
        decode(2'b00);
        chk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0);
        chk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
        chk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
        ret_exp++;

        run_r("sub", 3'b000, 1, 3'b001);
        run_r("add", 3'b000, 0, 3'b000);
        run_r("slt", 3'b010, 0, 3'b101);
        run_r("or",  3'b110, 0, 3'b011);
        run_i("addi_f7", 3'b000, 1, 3'b000);
        run_i("andi", 3'b111, 0, 3'b010);

        tname = "sw"; op = 7'b0100011; funct3 = 3'b010; funct7b5 = 0;
        fetch(2'b01);
        decode(2'b01);
        chk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0);
        chk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0);
        ret_exp++;

        tname = "jal"; op = 7'b1101111;
        fetch(2'b11);
        decode(2'b11);
        chk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0);
        chk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1, 0);
        ret_exp++;

        run_beq("beq_taken", 1);
        run_beq("beq_not_taken", 0);

        tname = "illegal"; op = 7'b0000000; Zero = 0;
        fetch(2'b00);
        chk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 1);

        // sw aborted by reset during MEMADR: the refetch also proves illegal did not retire
        tname = "sw_abort"; op = 7'b0100011; funct3 = 3'b010;
        fetch(2'b01);
        decode(2'b01);
        push_exp(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0);
        @(negedge clk);
        #1;
        rst = 0;
        ret_exp = '0;
        @(posedge clk);
        #1;
        tname = "abort_reset";
        in_reset(2'b01);
        in_reset(2'b01);
        rst = 1;
        tname = "sw_after_reset";
        fetch(2'b01);
        decode(2'b01);
        chk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0);
        chk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0);
        ret_exp++;
        tname = "final_fetch"; op = 7'b0000000;
        fetch(2'b00);

        for (int i = 0; i < 5; i++) begin
            if (q_exp.size() == 0) break;
            @(posedge clk);
        end
        if (q_exp.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Main control unit for the multicycle RV32I core. It sits directly upstream of the datapath in cpu and sequences every instruction through Fetch/Decode/Execute/Memory/Writeback. It drives all datapath enables and mux selects from the latched instruction fields and the ALU Zero flag. It also provides a retired-instruction counter and an illegal-opcode pulse for the cpu testbench.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
op  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
Zero  in  1  ALU zero flag
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction/OldPC register enable
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
ALUSrcB  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4
ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RegWrite  out  1  register file write enable
illegal  out  1  one-cycle pulse on unsupported opcode
instr_retired  out  CNT_W  count of completed instructions

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, JAL, BEQ, ALUWB.
- Reset (rst=0, async): state=FETCH, instr_retired=0. PCWrite, IRWrite, MemWrite, RegWrite and illegal are forced to 0 while rst=0. The first FETCH executes on the first rising edge after rst rises.
- Transitions:
  - FETCH->DECODE.
  - DECODE: op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> FETCH with illegal=1 for that DECODE cycle.
  - MEMADR: op=0000011 -> MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB; EXECR, EXECI and JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- Moore outputs per state (unlisted enables = 0; unlisted selects = 00):
  - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1, ALUOp=00.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1, ALUOp=00.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1.
  - ALUWB: ResultSrc=00, RegWrite=1.
- PCWrite = PCUpdate | (Branch & Zero). This is the only output combinational on Zero.
- ImmSrc, combinational on op: lw/I-type 00, sw 01, beq 10, jal 11, others 00.
- ALUControl, combinational:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, by funct3:
    - 000 -> 001 if op[5]&funct7b5, else 000.
    - 010 -> 101.
    - 110 -> 011.
    - 111 -> 010.
    - other -> 000.
- Latency (cycles, FETCH to next FETCH): lw 5; sw, R, I, jal 4; beq 3; illegal 2.
- instr_retired increments by 1 on each clock edge leaving MEMWB, MEMWRITE, ALUWB or BEQ. It does not increment on illegal. It wraps modulo 2^CNT_W.
- op, funct3 and funct7b5 are required stable from the end of FETCH until return to FETCH (IR held by datapath). The block does not latch them.
- Reset asserted mid-instruction aborts immediately to FETCH. No partial write enable is emitted after rst falls.

Test Plan:
- Reset hold 3 cycles, release -> FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10; during reset all four enables read 0.
- lw (op=0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles; RegWrite=1 only in cycle 5 with ResultSrc=01; instr_retired 0->1.
- sub (op=0110011, funct3=000, funct7b5=1) -> EXECR shows ALUControl=001; add (funct7b5=0) shows 000; slt (funct3=010) shows 101; each takes 4 cycles.
- beq with Zero=1 in BEQ -> PCWrite=1 in cycle 3; repeat with Zero=0 -> PCWrite=0; both increment instr_retired.
- op=0000000 -> illegal=1 in DECODE for exactly 1 cycle, back to FETCH next cycle; instr_retired unchanged.
- sw, then rst pulsed low during MEMADR -> MemWrite never asserts; state=FETCH and instr_retired=0 after reset.
